stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Stopwatch sequencer driven by the 100 Hz divided clock. Edge-detects the divided
//  clock in the clk_in domain, runs a start/stop/lap/clear FSM, keeps a cascaded
//  min:sec:centisecond count and drives frozen (lap) or live values to the display.
//  Sits between the 100 Hz clock divider and the 7-segment display mux.
// PARAMETERS
//  TICKS_PER_SEC  100  ticks per second; fraction counter wraps at TICKS_PER_SEC-1
//  MAX_MIN        59   last minute value before full wrap to 0:00:00
// PORTS
//  clk_in      in   1   system clock (100 MHz); the only clock
//  rst_n       in   1   asynchronous, active-low reset
//  clk_100hz   in   1   divided clock level; divider registers it on clk_in
//  btn_ss      in   1   start/stop, one-cycle pulse, debounced upstream
//  btn_lap     in   1   lap toggle, one-cycle pulse
//  btn_clr     in   1   clear, one-cycle pulse
//  disp_cs     out  $clog2(TICKS_PER_SEC)  displayed fraction (7 b at default)
//  disp_sec    out  6   displayed seconds 0..59
//  disp_min    out  $clog2(MAX_MIN+1)      displayed minutes (6 b at default)
//  running     out  1   1 in RUN or LAP
//  lap_active  out  1   1 in LAP (display frozen)
//  ovf         out  1   one-cycle pulse on full wrap
// BEHAVIOUR
//  Reset: state IDLE; all counters, snapshot, disp_*, running, lap_active, ovf = 0.
//  Tick: clk_100hz_q registered each cycle; tick = clk_100hz & ~clk_100hz_q (one
//   clk_in cycle per 100 Hz period). Counters update on the edge ending the tick
//   cycle, so disp_* change 1 cycle after clk_100hz is first sampled high.
//  Counting (state RUN or LAP, tick=1), evaluated on current state:
//   cs<TICKS_PER_SEC-1: cs+1. Else cs=0 and carry to sec.
//   sec<59: sec+1. Else sec=0 and carry to min.
//   min<MAX_MIN: min+1. Else min=0, ovf=1 for that cycle; counting continues.
//  FSM (priority per cycle: btn_clr > btn_ss > btn_lap; lower ones ignored):
//   IDLE : btn_ss -> RUN. btn_clr, btn_lap: no effect.
//   RUN  : btn_ss -> PAUSE. btn_lap -> LAP, snapshot <= post-tick count of
//          that cycle. btn_clr ignored.
//   LAP  : btn_lap -> RUN (display returns to live). btn_ss -> PAUSE (display
//          live). btn_clr ignored.
//   PAUSE: btn_ss -> RUN. btn_clr -> IDLE, counters zeroed same edge. btn_lap: no effect.
//  Display: disp_* = snapshot in LAP, else live counters; registered outputs.
//  Simultaneous events: tick with btn_ss in RUN -> tick counted, then PAUSE.
//   Tick with btn_ss in IDLE/PAUSE -> tick not counted; counting starts next tick.
//   Tick with btn_clr in PAUSE -> counters 0 (clear wins).
//  Reset mid-operation: asynchronous return to reset values; no pending tick kept.
//  clk_100hz held constant: no ticks, counters hold in every state.
// TESTING
//  1 Reset, btn_ss, 150 ticks -> disp 0:01:50, running=1, ovf never set.
//  2 Preload 59:59:98 (MAX_MIN=59), 2 ticks -> 59:59:99 then 0:00:00, ovf one cycle.
//  3 RUN at 0:02:10, btn_lap, 30 ticks -> disp stays 0:02:10, lap_active=1;
//    btn_lap -> disp 0:02:40 next cycle.
//  4 RUN, btn_ss, 20 ticks -> count unchanged; btn_clr -> IDLE, all 0, running=0.
//  5 Same-cycle btn_clr+btn_ss in PAUSE -> IDLE zeroed; btn_ss+tick in RUN ->
//    +1 then PAUSE; btn_clr in RUN -> ignored.
//  6 rst_n low mid-RUN between clk_in edges -> outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: edge-detects the 100 Hz level, runs the
// start/stop/lap/clear FSM, keeps a min:sec:cs count and drives
// either the live count or a frozen lap snapshot to the display.
module stopwatch_ctrl #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MAX_MIN       = 59,
    localparam int CW = $clog2(TICKS_PER_SEC),
    localparam int MW = $clog2(MAX_MIN + 1)
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          clk_100hz,
    input  logic          btn_ss,
    input  logic          btn_lap,
    input  logic          btn_clr,
    output logic [CW-1:0] disp_cs,
    output logic [5:0]    disp_sec,
    output logic [MW-1:0] disp_min,
    output logic          running,
    output logic          lap_active,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    typedef struct packed {
        logic [CW-1:0] cs;
        logic [5:0]    sec;
        logic [MW-1:0] mn;
    } cnt_t;

    state_t  state, state_nxt;
    logic    clk_100hz_q;
    logic    tick;
    logic    do_clr;
    logic    take_snap;
    logic    wrap;
    cnt_t    cnt, cnt_nxt, cnt_inc;
    cnt_t    snap, snap_nxt;

    assign tick = clk_100hz & ~clk_100hz_q;

    // Previous level of the divided clock for rising-edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) clk_100hz_q <= 1'b0;
        else        clk_100hz_q <= clk_100hz;
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; clear is only meaningful in PAUSE, start/stop outranks lap
    always_comb begin
        state_nxt = state;
        do_clr    = 1'b0;
        take_snap = 1'b0;
        unique case (state)
            IDLE:  if (btn_ss) state_nxt = RUN;
            RUN: begin
                if (btn_ss) state_nxt = PAUSE;
                else if (btn_lap) begin
                    state_nxt = LAP;
                    take_snap = 1'b1;
                end
            end
            LAP: begin
                if (btn_ss)       state_nxt = PAUSE;
                else if (btn_lap) state_nxt = RUN;
            end
            PAUSE: begin
                if (btn_clr) begin
                    state_nxt = IDLE;
                    do_clr    = 1'b1;
                end else if (btn_ss) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cascaded increment of the count; wrap flags the full rollover
    always_comb begin
        cnt_inc = cnt;
        wrap    = 1'b0;
        if (cnt.cs != CW'(TICKS_PER_SEC - 1)) begin
            cnt_inc.cs = cnt.cs + 1'b1;
        end else begin
            cnt_inc.cs = '0;
            if (cnt.sec != 6'd59) begin
                cnt_inc.sec = cnt.sec + 1'b1;
            end else begin
                cnt_inc.sec = '0;
                if (cnt.mn != MW'(MAX_MIN)) begin
                    cnt_inc.mn = cnt.mn + 1'b1;
                end else begin
                    cnt_inc.mn = '0;
                    wrap       = 1'b1;
                end
            end
        end
    end

    // Post-tick count for this cycle; a tick only counts in RUN/LAP, clear wins
    always_comb begin
        cnt_nxt  = cnt;
        snap_nxt = snap;
        if (do_clr)
            cnt_nxt = '0;
        else if (tick && (state == RUN || state == LAP))
            cnt_nxt = cnt_inc;
        if (take_snap)
            snap_nxt = cnt_nxt;
    end

    // Count, snapshot, display and overflow pulse registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            snap     <= '0;
            disp_cs  <= '0;
            disp_sec <= '0;
            disp_min <= '0;
            ovf      <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            snap <= snap_nxt;
            ovf  <= wrap && tick && !do_clr && (state == RUN || state == LAP);
            if (state_nxt == LAP) begin
                disp_cs  <= snap_nxt.cs;
                disp_sec <= snap_nxt.sec;
                disp_min <= snap_nxt.mn;
            end else begin
                disp_cs  <= cnt_nxt.cs;
                disp_sec <= cnt_nxt.sec;
                disp_min <= cnt_nxt.mn;
            end
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        running    = (state == RUN) || (state == LAP);
        lap_active = (state == LAP);
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: vector table for single-cycle behaviour plus hand
// sequences for long counts, lap freeze, wrap and asynchronous reset.
module tb_stopwatch_ctrl;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_100hz = 1'b0;
    logic btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;

    logic [6:0] disp_cs;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       running, lap_active, ovf;

    // Small instance (2 ticks/s, 2 minutes) so a full wrap is reachable quickly
    logic [0:0] b_cs;
    logic [5:0] b_sec;
    logic [0:0] b_min;
    logic       b_running, b_lap_active, b_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    stopwatch_ctrl dut (
        .clk_in(clk_in), .rst_n(rst_n), .clk_100hz(clk_100hz),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .disp_cs(disp_cs), .disp_sec(disp_sec), .disp_min(disp_min),
        .running(running), .lap_active(lap_active), .ovf(ovf)
    );

    stopwatch_ctrl #(.TICKS_PER_SEC(2), .MAX_MIN(1)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .clk_100hz(clk_100hz),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .disp_cs(b_cs), .disp_sec(b_sec), .disp_min(b_min),
        .running(b_running), .lap_active(b_lap_active), .ovf(b_ovf)
    );

    typedef struct {
        bit ss, lap, clr, hz;
        int cs, sec, mn;
        bit run, lapa, ov;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int cs, input int sec, input int mn,
                         input bit run, input bit lapa, input bit ov);
        n_cmp++;
        if (int'(disp_cs) != cs || int'(disp_sec) != sec || int'(disp_min) != mn ||
            running != run || lap_active != lapa || ovf != ov) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d:%0d run=%0b lap=%0b ovf=%0b, want %0d:%0d:%0d run=%0b lap=%0b ovf=%0b",
                     name, disp_min, disp_sec, disp_cs, running, lap_active, ovf,
                     mn, sec, cs, run, lapa, ov);
        end
    endtask

    task automatic check_b(input string name, input int cs, input int sec, input int mn,
                           input bit ov);
        n_cmp++;
        if (int'(b_cs) != cs || int'(b_sec) != sec || int'(b_min) != mn || b_ovf != ov) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d:%0d ovf=%0b, want %0d:%0d:%0d ovf=%0b",
                     name, b_min, b_sec, b_cs, b_ovf, mn, sec, cs, ov);
        end
    endtask

    task automatic apply(input bit ss, input bit lap, input bit clr, input bit hz);
        @(negedge clk_in);
        btn_ss = ss; btn_lap = lap; btn_clr = clr; clk_100hz = hz;
        @(posedge clk_in);
        #1;
    endtask

    bit ovf_seen, b_ovf_seen;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(0, 0, 0, 1);
            if (ovf) ovf_seen = 1;
            if (b_ovf) b_ovf_seen = 1;
            apply(0, 0, 0, 0);
            if (ovf) ovf_seen = 1;
            if (b_ovf) b_ovf_seen = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        btn_ss = 0; btn_lap = 0; btn_clr = 0; clk_100hz = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    function automatic vec_t v(bit ss, bit lap, bit clr, bit hz, int cs,
                               bit run, bit lapa);
        vec_t r;
        r.ss = ss; r.lap = lap; r.clr = clr; r.hz = hz;
        r.cs = cs; r.sec = 0; r.mn = 0; r.run = run; r.lapa = lapa; r.ov = 0;
        return r;
    endfunction

    initial begin
        //          ss lap clr hz  cs run lap
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0)); // idle holds
        vt.push_back(v(1, 0, 0, 0, 0, 1, 0)); // start
        vt.push_back(v(0, 0, 0, 1, 1, 1, 0)); // tick
        vt.push_back(v(0, 0, 0, 1, 1, 1, 0)); // level held: no tick
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0));
        vt.push_back(v(0, 1, 0, 1, 2, 1, 1)); // lap with tick: snapshot post-tick
        vt.push_back(v(0, 0, 0, 0, 2, 1, 1));
        vt.push_back(v(0, 0, 0, 1, 2, 1, 1)); // live=3, display frozen
        vt.push_back(v(0, 0, 0, 0, 2, 1, 1));
        vt.push_back(v(0, 1, 0, 0, 3, 1, 0)); // lap off: live again
        vt.push_back(v(1, 0, 0, 1, 4, 0, 0)); // stop with tick: counted, pause
        vt.push_back(v(0, 0, 0, 0, 4, 0, 0));
        vt.push_back(v(0, 0, 0, 1, 4, 0, 0)); // tick in pause ignored
        vt.push_back(v(0, 0, 0, 0, 4, 0, 0));
        vt.push_back(v(1, 0, 0, 0, 4, 1, 0)); // resume
        vt.push_back(v(0, 0, 1, 1, 5, 1, 0)); // clear ignored in run
        vt.push_back(v(1, 0, 0, 0, 5, 0, 0)); // pause
        vt.push_back(v(0, 0, 1, 1, 0, 0, 0)); // clear with tick in pause: zero
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0)); // lap in idle: nothing
        vt.push_back(v(1, 0, 0, 0, 0, 1, 0)); // start
        vt.push_back(v(0, 0, 0, 1, 1, 1, 0));
        vt.push_back(v(1, 0, 0, 0, 1, 0, 0)); // pause
        vt.push_back(v(1, 0, 1, 0, 0, 0, 0)); // clear beats start in pause
        vt.push_back(v(0, 0, 0, 1, 0, 0, 0)); // tick in idle ignored
        vt.push_back(v(1, 0, 0, 0, 0, 1, 0)); // start
        vt.push_back(v(0, 1, 0, 1, 1, 1, 1)); // lap at 1
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1));
        vt.push_back(v(0, 0, 0, 1, 1, 1, 1)); // live 2
        vt.push_back(v(1, 0, 0, 0, 2, 0, 0)); // stop from lap: live shown
        vt.push_back(v(0, 1, 0, 0, 2, 0, 0)); // lap in pause: nothing
        vt.push_back(v(0, 0, 1, 0, 0, 0, 0)); // clear

        // Reset state
        do_reset();
        #1;
        check("reset", 0, 0, 0, 0, 0, 0);
        check_b("reset_b", 0, 0, 0, 0);

        // Vector table
        foreach (vt[i]) begin
            apply(vt[i].ss, vt[i].lap, vt[i].clr, vt[i].hz);
            check($sformatf("vec%0d", i), vt[i].cs, vt[i].sec, vt[i].mn,
                  vt[i].run, vt[i].lapa, vt[i].ov);
        end

        // 150 ticks from zero -> 0:01:50
        do_reset();
        ovf_seen = 0;
        apply(1, 0, 0, 0);
        ticks(150);
        check("run150", 50, 1, 0, 1, 0, 0);
        n_cmp++;
        if (ovf_seen) begin
            n_err++;
            $display("FAIL ovf150: ovf seen=1, want 0");
        end

        // Continue to 0:02:10, lap, 30 ticks frozen, then unfreeze at 0:02:40
        ticks(60);
        check("at210", 10, 2, 0, 1, 0, 0);
        apply(0, 1, 0, 0);
        ticks(30);
        check("lapfrozen", 10, 2, 0, 1, 1, 0);
        apply(0, 1, 0, 0);
        check("lapoff", 40, 2, 0, 1, 0, 0);

        // Pause holds through ticks, clear returns to idle
        apply(1, 0, 0, 0);
        ticks(20);
        check("paused", 40, 2, 0, 0, 0, 0);
        apply(0, 0, 1, 0);
        check("cleared", 0, 0, 0, 0, 0, 0);

        // Full wrap on the small instance: 239 ticks -> 1:59:1, then 0:00:00
        do_reset();
        b_ovf_seen = 0;
        apply(1, 0, 0, 0);
        ticks(239);
        check_b("prewrap", 1, 59, 1, 0);
        n_cmp++;
        if (b_ovf_seen) begin
            n_err++;
            $display("FAIL earlyovf: ovf seen=1, want 0");
        end
        apply(0, 0, 0, 1);
        check_b("wrap", 0, 0, 0, 1);
        apply(0, 0, 0, 0);
        check_b("wrapovfoff", 0, 0, 0, 0);
        apply(0, 0, 0, 1);
        check_b("afterwrap", 1, 0, 0, 0);

        // Asynchronous reset between edges while running
        do_reset();
        apply(1, 0, 0, 0);
        ticks(5);
        check("prereset", 5, 0, 0, 1, 0, 0);
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncrst", 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        ticks(3);
        check("idleafter", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout, want completion");
        $fatal(1);
    end

endmodule
